pipeadc_dec: RTL and testbench

- Digital error-correction and time-alignment stage for the 3-bit pipelined ADC. Sits directly downstream of the per-stage one-hot-to-binary converters.
- Each 1.5-bit stage delivers a 2-bit code d_k in {0,1,2}. The backend flash delivers a FLASH_BITS code. Because the analog pipeline skews these codes in time, the block delays each code so that all codes of one sample line up.
- It then adds the aligned codes with 1-bit overlap and registers the OUT_BITS result with a valid strobe.

---
 rtl/pipeadc_pkg.sv | 17 +
 rtl/pipeadc_delay_line.sv | 41 ++++
 rtl/pipeadc_dec.sv | 94 +++++++++
 tb/tb_pipeadc_dec.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeadc_pkg.sv
// Shared constants and helpers for the pipelined-ADC digital correction stage.
package pipeadc_pkg;

    localparam int STAGE_CODE_W = 2;

    typedef logic [STAGE_CODE_W-1:0] stage_code_t;

    localparam stage_code_t CODE_ILLEGAL = 2'b11;
    localparam stage_code_t CODE_MAX     = 2'd2;

    // A 1.5-bit stage can only legally produce 0..2; an out-of-range code is
    // clamped to the largest legal value so the sum stays within range.
    function automatic stage_code_t legalize_code(input stage_code_t code);
        return (code == CODE_ILLEGAL) ? CODE_MAX : code;
    endfunction

endpackage

// File: rtl/pipeadc_delay_line.sv
// Fixed-depth register delay line with synchronous active-low reset.
// DEPTH = 0 degenerates to a plain wire.
module pipeadc_delay_line
    import pipeadc_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n;
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] taps [DEPTH];

            // Shift the input one tap per cycle; reset flushes every tap.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        taps[i] <= '0;
                    end
                end else begin
                    taps[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps[i] <= taps[i-1];
                    end
                end
            end

            assign q = taps[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pipeadc_dec.sv
// Pipelined-ADC error correction: time-aligns the skewed stage codes and the
// flash code of each sample, adds them with 1-bit overlap and registers the
// corrected word together with a valid strobe and a sticky illegal-code flag.
module pipeadc_dec
    import pipeadc_pkg::*;
#(
    parameter  int N_STAGES   = 2,
    parameter  int FLASH_BITS = 1,
    localparam int OUT_BITS   = N_STAGES + FLASH_BITS
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic [STAGE_CODE_W*N_STAGES-1:0]   stage_code_i,
    input  logic [FLASH_BITS-1:0]              flash_code_i,
    input  logic                               clr_err_i,
    output logic [OUT_BITS-1:0]                data_o,
    output logic                               valid_o,
    output logic                               err_o
);

    localparam int SUM_W = OUT_BITS + 1;

    stage_code_t        aligned_code [N_STAGES];
    logic               aligned_valid;
    logic [SUM_W-1:0]   sum;
    logic               code_bad;
    logic               illegal_hit;
    logic               unused_sum_msb;

    // Stage k arrives k cycles after stage 0, so it needs N_STAGES-k delays to
    // line up with the flash code, which arrives last and is used directly.
    genvar k;
    generate
        for (k = 0; k < N_STAGES; k++) begin : g_align
            pipeadc_delay_line #(
                .WIDTH (STAGE_CODE_W),
                .DEPTH (N_STAGES - k)
            ) u_code_dly (
                .clk   (clk_i),
                .rst_n (rst_ni),
                .d     (stage_code_i[STAGE_CODE_W*k +: STAGE_CODE_W]),
                .q     (aligned_code[k])
            );
        end
    endgenerate

    pipeadc_delay_line #(
        .WIDTH (1),
        .DEPTH (N_STAGES)
    ) u_valid_dly (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (en_i),
        .q     (aligned_valid)
    );

    // Overlap-add the aligned codes: earlier stages carry more weight, each
    // stage overlapping the next by one bit; also spot any illegal code.
    always_comb begin
        sum      = SUM_W'(flash_code_i);
        code_bad = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            sum = sum + (SUM_W'(legalize_code(aligned_code[i])) << (FLASH_BITS + N_STAGES - 2 - i));
            if (aligned_code[i] == CODE_ILLEGAL) begin
                code_bad = 1'b1;
            end
        end
    end

    assign illegal_hit    = aligned_valid & code_bad;
    assign unused_sum_msb = sum[OUT_BITS];

    // Output register loads only for valid samples so gaps hold the last
    // word; the error flag is sticky and a new illegal code beats a clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= aligned_valid;
            if (aligned_valid) begin
                data_o <= sum[OUT_BITS-1:0];
            end
            if (illegal_hit) begin
                err_o <= 1'b1;
            end else if (clr_err_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeadc_dec.sv
// Scoreboard bench for pipeadc_dec: a per-cycle stimulus table (directed
// segments followed by random traffic) drives the DUT; expected samples are
// queued as they are issued and a monitor pops and compares them.
module tb_pipeadc_dec;

    localparam int N_STAGES   = 2;
    localparam int FLASH_BITS = 1;
    localparam int OUT_BITS   = N_STAGES + FLASH_BITS;

    typedef struct packed {
        bit                          en;
        bit                          rst_n;
        bit                          clr;
        bit [N_STAGES-1:0][1:0]      d;
        bit [FLASH_BITS-1:0]         flash;
    } row_t;

    typedef struct {
        int due;
        int data;
    } exp_t;

    logic                        clk;
    logic                        rst_ni;
    logic                        en_i;
    logic [2*N_STAGES-1:0]       stage_code_i;
    logic [FLASH_BITS-1:0]       flash_code_i;
    logic                        clr_err_i;
    logic [OUT_BITS-1:0]         data_o;
    logic                        valid_o;
    logic                        err_o;

    row_t  tbl [$];
    exp_t  sb [$];
    int    exp_data [];
    bit    exp_err [];
    int    vectors;
    int    miscompares;

    pipeadc_dec #(
        .N_STAGES   (N_STAGES),
        .FLASH_BITS (FLASH_BITS)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .stage_code_i (stage_code_i),
        .flash_code_i (flash_code_i),
        .clr_err_i    (clr_err_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one cycle of stimulus; the codes belong to the sample started in that cycle.
    task automatic add_row(input bit en, input bit rst_n, input bit clr,
                           input int d0, input int d1, input int fl);
        row_t r;
        r.en    = en;
        r.rst_n = rst_n;
        r.clr   = clr;
        r.d[0]  = 2'(d0);
        r.d[1]  = 2'(d1);
        r.flash = FLASH_BITS'(fl);
        tbl.push_back(r);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_row(1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    function automatic int rand_code();
        if ($urandom_range(0, 15) == 0) return 3;
        return int'($urandom_range(0, 2));
    endfunction

    // Weighted overlap sum of one sample, with an out-of-range stage code read as 2.
    function automatic int sample_value(input row_t r);
        int v;
        int code;
        v = int'(r.flash);
        for (int k = 0; k < N_STAGES; k++) begin
            code = int'(r.d[k]);
            if (code == 3) code = 2;
            v += code * (2 ** (FLASH_BITS + N_STAGES - 2 - k));
        end
        return v % (2 ** OUT_BITS);
    endfunction

    function automatic bit has_illegal(input row_t r);
        for (int k = 0; k < N_STAGES; k++) begin
            if (r.d[k] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A sample reaches the output only if reset stays inactive from its
    // start cycle until its last code is captured.
    function automatic bit survives(input int c);
        if (c < 0 || c >= tbl.size()) return 1'b0;
        if (!tbl[c].en) return 1'b0;
        for (int j = c; j <= c + N_STAGES; j++) begin
            if (j < tbl.size() && !tbl[j].rst_n) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic build_table();
        int s;
        // reset held with enable and random codes, then one fill sample
        for (int i = 0; i < 3; i++) add_row(1'b1, 1'b0, 1'b0, rand_code(), rand_code(), $urandom_range(0, 1));
        add_idle(2);
        add_row(1'b1, 1'b1, 1'b0, 1, 2, 1);
        add_idle(4);
        // alignment: surrounding cycles carry opposite codes
        for (int i = 0; i < 2; i++) add_row(1'b0, 1'b1, 1'b0, 2, 2, 0);
        add_row(1'b1, 1'b1, 1'b0, 1, 1, 1);
        for (int i = 0; i < 4; i++) add_row(1'b0, 1'b1, 1'b0, 2, 2, 0);
        // extremes back to back
        for (int i = 0; i < 2; i++) begin
            add_row(1'b1, 1'b1, 1'b0, 0, 0, 0);
            add_row(1'b1, 1'b1, 1'b0, 2, 2, 1);
        end
        add_idle(4);
        // enable gap 1,0,1,1
        add_row(1'b1, 1'b1, 1'b0, 1, 0, 1);
        add_row(1'b0, 1'b1, 1'b0, 2, 2, 1);
        add_row(1'b1, 1'b1, 1'b0, 2, 1, 0);
        add_row(1'b1, 1'b1, 1'b0, 0, 2, 1);
        add_idle(4);
        // illegal code, hold, clear, then clear coincident with a new one
        add_row(1'b1, 1'b1, 1'b0, 3, 0, 0);
        add_idle(6);
        add_row(1'b0, 1'b1, 1'b1, 0, 0, 0);
        add_idle(2);
        s = tbl.size();
        add_row(1'b1, 1'b1, 1'b0, 3, 1, 1);
        add_idle(5);
        tbl[s + N_STAGES].clr = 1'b1;
        // reset while two samples are in flight
        add_row(1'b1, 1'b1, 1'b0, 1, 1, 0);
        add_row(1'b1, 1'b1, 1'b0, 2, 0, 1);
        add_row(1'b0, 1'b0, 1'b0, 0, 0, 0);
        add_idle(2);
        add_row(1'b1, 1'b1, 1'b0, 2, 1, 0);
        add_idle(4);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            add_row($urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0,
                    $urandom_range(0, 19) == 0, rand_code(), rand_code(),
                    $urandom_range(0, 1));
        end
        add_idle(N_STAGES + 4);
    endtask

    // Expected hold value and error flag for every output cycle x, where
    // cycle x shows the result of the edge that sampled table row x-1.
    task automatic build_expect();
        int c;
        bit v;
        exp_data = new[tbl.size() + 1];
        exp_err  = new[tbl.size() + 1];
        exp_data[0] = 0;
        exp_err[0]  = 1'b0;
        for (int x = 1; x <= tbl.size(); x++) begin
            if (!tbl[x-1].rst_n) begin
                exp_data[x] = 0;
                exp_err[x]  = 1'b0;
            end else begin
                c = x - N_STAGES - 1;
                v = survives(c);
                exp_data[x] = v ? sample_value(tbl[c]) : exp_data[x-1];
                if (v && has_illegal(tbl[c]))  exp_err[x] = 1'b1;
                else if (tbl[x-1].clr)         exp_err[x] = 1'b0;
                else                           exp_err[x] = exp_err[x-1];
            end
        end
    endtask

    task automatic check_output(input string name, input int actual, input int expected, input int cyc);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Drive one table row; stage k of the current cycle belongs to the
    // sample started k cycles earlier, the flash to the one N_STAGES earlier.
    task automatic apply_stimulus(input int c);
        logic [2*N_STAGES-1:0] sc;
        exp_t e;
        sc = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            if (c - k >= 0) sc[2*k +: 2] = tbl[c-k].d[k];
        end
        rst_ni       = tbl[c].rst_n;
        en_i         = tbl[c].en;
        clr_err_i    = tbl[c].clr;
        stage_code_i = sc;
        flash_code_i = (c >= N_STAGES) ? tbl[c-N_STAGES].flash : '0;
        if (survives(c)) begin
            e.due  = c + N_STAGES + 1;
            e.data = sample_value(tbl[c]);
            sb.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        bit   due_now;
        vectors     = 0;
        miscompares = 0;
        rst_ni       = 1'b0;
        en_i         = 1'b0;
        clr_err_i    = 1'b0;
        stage_code_i = '0;
        flash_code_i = '0;
        build_table();
        build_expect();
        $display("[TB] %0d stimulus cycles", tbl.size());
        fork
            begin
                apply_stimulus(0);
                for (int c = 1; c < tbl.size(); c++) begin
                    @(posedge clk);
                    #1;
                    apply_stimulus(c);
                end
            end
            begin
                for (int x = 1; x <= tbl.size(); x++) begin
                    @(posedge clk);
                    @(negedge clk);
                    due_now = (sb.size() > 0) && (sb[0].due == x);
                    check_output("valid_o", int'(valid_o === 1'b1), int'(due_now), x);
                    check_output("err_o", int'(err_o === 1'b1), int'(exp_err[x]), x);
                    if (valid_o === 1'b1 && sb.size() > 0) begin
                        e = sb.pop_front();
                        check_output("latency", x, e.due, x);
                        check_output("data_o", int'(data_o), e.data, x);
                    end else begin
                        if (due_now) void'(sb.pop_front());
                        check_output("data_hold", int'(data_o), exp_data[x], x);
                    end
                end
            end
        join
        check_output("drain", sb.size(), 0, tbl.size());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
